vwb_collector: RTL

- Consumer end of the vector functional-unit result stream (`{valid, mask, result}`, DATA_WIDTH+2 bits) driven by the vector arithmetic wrappers.
- Counts VLR result elements in arrival order and buffers them in a small FIFO.
- Drives the destination vector-register write port with backpressure, skipping masked-off elements.
- Reports in-order retirement progress for chaining, plus busy/done status.

---
 rtl/vwb_pkg.sv | 30 +++
 rtl/vwb_fifo.sv | 42 ++++
 rtl/vwb_collector.sv | 112 +++++++++++
 3 files changed

// File: rtl/vwb_pkg.sv
// Shared helpers for the vector write-back collector: width functions,
// result-stream field positions and the controller state encoding.
package vwb_pkg;

  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int bitwidth(input int n);
    return log2(n);
  endfunction

  function automatic int valid_bit(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int mask_bit(input int data_width);
    return data_width;
  endfunction

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } vwb_state_e;

endpackage

// File: rtl/vwb_fifo.sv
// Synchronous result buffer; a push into a full FIFO is taken when a pop
// happens in the same cycle.
module vwb_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vwb_collector.sv
// Collects VLR functional-unit results in order, buffers them and retires
// them to the vector register file, skipping masked-off elements.
//   state   | meaning
//   IDLE    | waiting for start; stray results ignored
//   COLLECT | counting arrivals, retiring buffered elements
module vwb_collector
  import vwb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MVL        = 32,
  parameter int NREGS      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [log2(NREGS)-1:0]     dest_reg,
  input  logic [bitwidth(MVL):0]     VLR,
  input  logic [DATA_WIDTH+1:0]      fu_in,
  input  logic                       wr_ready,
  output logic                       wr_en,
  output logic [log2(NREGS)-1:0]     wr_reg,
  output logic [bitwidth(MVL)-1:0]   wr_idx,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [bitwidth(MVL):0]     elem_done,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);
  localparam int IW = bitwidth(MVL);
  localparam int CW = IW + 1;
  localparam int RW = log2(NREGS);
  localparam int EW = 1 + IW + DATA_WIDTH;
  localparam int VB = valid_bit(DATA_WIDTH);
  localparam int MB = mask_bit(DATA_WIDTH);

  vwb_state_e      state, state_nxt;
  logic [CW-1:0]   vlr_reg, in_cnt;
  logic [RW-1:0]   reg_q;
  logic [EW-1:0]   head;
  logic            fifo_full, fifo_empty;
  logic            head_valid, head_mask, pop, push_req, push, ovf_set, finish;

  vwb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fu_in[MB], in_cnt[IW-1:0], fu_in[DATA_WIDTH-1:0]}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_valid = !fifo_empty;
  assign head_mask  = head[EW-1];
  assign wr_en      = head_valid && head_mask;
  assign wr_reg     = reg_q;
  assign wr_idx     = head[DATA_WIDTH +: IW];
  assign wr_data    = head[DATA_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    pop       = head_valid && (!head_mask || wr_ready);
    push_req  = (state == COLLECT) && fu_in[VB] && (in_cnt < vlr_reg);
    push      = push_req && (!fifo_full || pop);
    // Dropped arrivals and arrivals past VLR both flag overflow.
    ovf_set   = (state == COLLECT) && fu_in[VB] && !push;
    finish    = (state == COLLECT) && pop && ((elem_done + CW'(1)) == vlr_reg);
    case (state)
      IDLE:    if (start && (VLR != '0)) state_nxt = COLLECT;
      COLLECT: if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      vlr_reg   <= '0;
      reg_q     <= '0;
      in_cnt    <= '0;
      elem_done <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          vlr_reg   <= VLR;
          reg_q     <= dest_reg;
          in_cnt    <= '0;
          elem_done <= '0;
          overflow  <= 1'b0;
          busy      <= (VLR != '0);
          done      <= (VLR == '0);
        end
      end else begin
        if (push_req) in_cnt    <= in_cnt + CW'(1);
        if (pop)      elem_done <= elem_done + CW'(1);
        if (ovf_set)  overflow  <= 1'b1;
        if (finish) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
